// File: rtl/req_pend_pkg.sv
// ---------------------------------------------------------------------------
// req_pend_pkg
// Shared constants, state encoding and helpers for the req_pend_arb slice.
//   REQ_W   : number of request lines (fixed at 8, matches prio_enco_8x3)
//   IDX_W   : width of a granted index
//   state_t : arbiter FSM state
//   onehot  : index -> REQ_W-bit single-bit mask
// ---------------------------------------------------------------------------
package req_pend_pkg;

    localparam int REQ_W = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic logic [REQ_W-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [REQ_W-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/req_pend_arb_if.sv
// ---------------------------------------------------------------------------
// req_pend_arb_if
// Request/mask inputs and valid/ready grant outputs of req_pend_arb.
//   req_in    : raw request lines
//   mask      : per-line grant enable (1 = eligible)
//   out_ready : downstream accepts the grant
//   out_valid : grant index valid
//   out_idx   : granted index
//   pending   : sticky pending register
// Modports: slave = arbiter side, master = requester/consumer side.
// ---------------------------------------------------------------------------
interface req_pend_arb_if;
    import req_pend_pkg::*;

    logic [REQ_W-1:0] req_in;
    logic [REQ_W-1:0] mask;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic [REQ_W-1:0] pending;

    modport slave (
        input  req_in,
        input  mask,
        input  out_ready,
        output out_valid,
        output out_idx,
        output pending
    );

    modport master (
        output req_in,
        output mask,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  pending
    );

endinterface

// File: rtl/prio_enco_8x3.sv
// ---------------------------------------------------------------------------
// prio_enco_8x3
// Combinational 8-to-3 priority encoder, bit 7 highest priority.
//   d : request vector
//   q : index of the highest set bit (0 when d is all zero, which is
//       indistinguishable from d[0] set; callers must qualify with |d)
// ---------------------------------------------------------------------------
module prio_enco_8x3 (
    input  logic [7:0] d,
    output logic [2:0] q
);

    always_comb begin
        q = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) q = i[2:0];
        end
    end

endmodule

// File: rtl/req_pend_arb.sv
// ---------------------------------------------------------------------------
// req_pend_arb
// Captures request lines into sticky pending bits, masks them, and presents
// the highest-priority eligible index over valid/ready. The accepted bit is
// cleared on the handshake. A presented grant is never preempted.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   ovf  : (only with REQ_PEND_OVF_EN) sticky per-line lost-event flags
//   bus  : req_pend_arb_if.slave (req_in, mask, out_ready, out_valid,
//          out_idx, pending)
// Parameter EDGE_DET: 1 = rising edge of req_in sets pending,
//                     0 = high level sets pending every cycle.
// Optional feature macro: REQ_PEND_OVF_EN.
//
// state   | meaning
// IDLE    | no grant presented; loads highest eligible index when any
// PRESENT | out_valid high, out_idx frozen until out_ready
// ---------------------------------------------------------------------------
module req_pend_arb
    import req_pend_pkg::*;
#(
    parameter int EDGE_DET = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef REQ_PEND_OVF_EN
    output logic [REQ_W-1:0] ovf,
`endif
    req_pend_arb_if.slave    bus
);

    state_t           state_q, state_d;
    logic [REQ_W-1:0] pend_q, pend_d;
    logic [REQ_W-1:0] req_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REQ_W-1:0] set, clr, elig;
    logic [IDX_W-1:0] enc_idx;
    logic             accept;

    prio_enco_8x3 u_enc (
        .d (elig),
        .q (enc_idx)
    );

    // Set is ORed in after the clear so a same-cycle re-request survives.
    always_comb begin
        set    = (EDGE_DET != 0) ? (bus.req_in & ~req_q) : bus.req_in;
        accept = (state_q == PRESENT) && bus.out_ready;
        clr    = accept ? onehot(idx_q) : '0;
        pend_d = (pend_q & ~clr) | set;
        elig   = pend_q & bus.mask;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                // enc_idx is meaningless for an all-zero eligible vector.
                if (|elig) begin
                    idx_d   = enc_idx;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            req_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            req_q   <= bus.req_in;
            idx_q   <= idx_d;
        end
    end

    assign bus.out_valid = (state_q == PRESENT);
    assign bus.out_idx   = idx_q;
    assign bus.pending   = pend_q;

`ifdef REQ_PEND_OVF_EN
    logic [REQ_W-1:0] ovf_q, ovf_d;

    // A set landing on an already-pending bit that is not being serviced
    // this cycle merges into it, so one event is lost.
    always_comb begin
        ovf_d = (ovf_q & ~clr) | (set & pend_q & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= '0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_req_pend_arb.sv
module tb_req_pend_arb;
    import req_pend_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    int   sb_e[$];
    int   sb_l[$];

    req_pend_arb_if if_e ();
    req_pend_arb_if if_l ();

`ifdef REQ_PEND_OVF_EN
    logic [REQ_W-1:0] ovf_e;
    logic [REQ_W-1:0] ovf_l;
`endif

    req_pend_arb #(.EDGE_DET(1)) dut_e (
        .clk (clk),
        .rst (rst),
`ifdef REQ_PEND_OVF_EN
        .ovf (ovf_e),
`endif
        .bus (if_e)
    );

    req_pend_arb #(.EDGE_DET(0)) dut_l (
        .clk (clk),
        .rst (rst),
`ifdef REQ_PEND_OVF_EN
        .ovf (ovf_l),
`endif
        .bus (if_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Grant monitors: sample 1 time unit after the falling edge, when the
    // inputs for the next rising edge are settled.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && if_e.out_valid === 1'b1 && if_e.out_ready === 1'b1) begin
                check("grant_e_expected", 32'(sb_e.size() > 0), 32'd1);
                if (sb_e.size() > 0) begin
                    e = sb_e.pop_front();
                    check("grant_e_idx", 32'(if_e.out_idx), 32'(e));
                end
            end
        end
    end

    initial begin
        int e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && if_l.out_valid === 1'b1 && if_l.out_ready === 1'b1) begin
                check("grant_l_expected", 32'(sb_l.size() > 0), 32'd1);
                if (sb_l.size() > 0) begin
                    e = sb_l.pop_front();
                    check("grant_l_idx", 32'(if_l.out_idx), 32'(e));
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        if_e.req_in = '0; if_e.mask = 8'hFF; if_e.out_ready = 1'b1;
        if_l.req_in = '0; if_l.mask = 8'hFF; if_l.out_ready = 1'b1;

        // Reset state
        cyc(1);
        check("rst_valid", 32'(if_e.out_valid), 32'd0);
        check("rst_idx",   32'(if_e.out_idx),   32'd0);
        check("rst_pend",  32'(if_e.pending),   32'h00);
`ifdef REQ_PEND_OVF_EN
        check("rst_ovf",   32'(ovf_e),          32'h00);
`endif
        cyc(1);
        rst = 1'b0;

        // Basic order: pulse 8'b00010010 -> idx 4 then idx 1
        sb_e.push_back(4); sb_e.push_back(1);
        if_e.req_in = 8'h12;
        cyc(1);
        check("basic_pend0", 32'(if_e.pending),   32'h12);
        check("basic_v0",    32'(if_e.out_valid), 32'd0);
        if_e.req_in = 8'h00;
        cyc(1);
        check("basic_v1",    32'(if_e.out_valid), 32'd1);
        check("basic_idx1",  32'(if_e.out_idx),   32'd4);
        cyc(1);
        check("basic_pend2", 32'(if_e.pending),   32'h02);
        check("basic_v2",    32'(if_e.out_valid), 32'd0);
        cyc(1);
        check("basic_v3",    32'(if_e.out_valid), 32'd1);
        check("basic_idx3",  32'(if_e.out_idx),   32'd1);
        cyc(1);
        check("basic_pend4", 32'(if_e.pending),   32'h00);
        check("basic_v4",    32'(if_e.out_valid), 32'd0);

        // Backpressure and no preemption
        if_e.out_ready = 1'b0;
        if_e.req_in    = 8'h01;
        sb_e.push_back(0);
        cyc(1);
        if_e.req_in = 8'h00;
        cyc(1);
        check("bp_v",    32'(if_e.out_valid), 32'd1);
        check("bp_idx0", 32'(if_e.out_idx),   32'd0);
        if_e.req_in = 8'h80;
        cyc(1);
        if_e.req_in = 8'h00;
        cyc(1);
        check("bp_hold_idx",  32'(if_e.out_idx),   32'd0);
        check("bp_hold_v",    32'(if_e.out_valid), 32'd1);
        check("bp_hold_pend", 32'(if_e.pending),   32'h81);
        sb_e.push_back(7);
        if_e.out_ready = 1'b1;
        cyc(2);
        check("bp_idx7", 32'(if_e.out_idx), 32'd7);
        cyc(1);
        check("bp_pend_end", 32'(if_e.pending), 32'h00);

        // Masking: pending CC with mask 0F -> 3, 2, then hold C0
        if_e.mask   = 8'h0F;
        if_e.req_in = 8'hCC;
        sb_e.push_back(3); sb_e.push_back(2);
        cyc(1);
        check("mask_pend0", 32'(if_e.pending), 32'hCC);
        if_e.req_in = 8'h00;
        cyc(6);
        check("mask_hold_pend", 32'(if_e.pending),   32'hC0);
        check("mask_hold_v",    32'(if_e.out_valid), 32'd0);
        sb_e.push_back(7); sb_e.push_back(6);
        if_e.mask = 8'hFF;
        cyc(5);
        check("mask_pend_end", 32'(if_e.pending), 32'h00);

        // Set/clear collision on bit 2
        sb_e.push_back(2); sb_e.push_back(2);
        if_e.req_in = 8'h04;
        cyc(1);
        if_e.req_in = 8'h00;
        cyc(1);
        check("coll_v",   32'(if_e.out_valid), 32'd1);
        check("coll_idx", 32'(if_e.out_idx),   32'd2);
        if_e.req_in = 8'h04;
        cyc(1);
        check("coll_pend", 32'(if_e.pending),   32'h04);
        check("coll_v0",   32'(if_e.out_valid), 32'd0);
`ifdef REQ_PEND_OVF_EN
        check("coll_ovf",  32'(ovf_e),          32'h00);
`endif
        if_e.req_in = 8'h00;
        cyc(2);
        check("coll_pend_end", 32'(if_e.pending), 32'h00);

        // Level mode: req_in=04 held -> idx 2 every 2 cycles
        repeat (4) sb_l.push_back(2);
        if_l.req_in = 8'h04;
        cyc(2);
        check("lvl_v2", 32'(if_l.out_valid), 32'd1);
`ifdef REQ_PEND_OVF_EN
        check("lvl_ovf", 32'(ovf_l), 32'h04);
`endif
        cyc(1);
        check("lvl_v3", 32'(if_l.out_valid), 32'd0);
        cyc(5);
        check("lvl_v8", 32'(if_l.out_valid), 32'd1);
        if_l.req_in = 8'h00;
        cyc(2);
        check("lvl_pend_end", 32'(if_l.pending),   32'h00);
        check("lvl_v_end",    32'(if_l.out_valid), 32'd0);

        // Async reset mid-grant
        if_e.out_ready = 1'b0;
        if_e.req_in    = 8'hFF;
        cyc(1);
        if_e.req_in = 8'h00;
        cyc(1);
        check("ar_v_pre",    32'(if_e.out_valid), 32'd1);
        check("ar_pend_pre", 32'(if_e.pending),   32'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("ar_v_async",    32'(if_e.out_valid), 32'd0);
        check("ar_pend_async", 32'(if_e.pending),   32'h00);
        cyc(1);
        if_e.req_in    = 8'h10;
        if_e.out_ready = 1'b1;
        sb_e.push_back(4);
        rst = 1'b0;
        cyc(1);
        check("ar_v_e1", 32'(if_e.out_valid), 32'd0);
        cyc(1);
        check("ar_v_e2",   32'(if_e.out_valid), 32'd1);
        check("ar_idx_e2", 32'(if_e.out_idx),   32'd4);
        cyc(3);
        check("ar_pend_end", 32'(if_e.pending), 32'h00);

        check("sb_e_drained", 32'(sb_e.size()), 32'd0);
        check("sb_l_drained", 32'(sb_l.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
